// File: rtl/code_lock_entry.sv
// code_lock_entry: four-digit BCD code entry for a pushbutton/switch board.
//   CLOCK_50 - only clock, everything changes on its rising edge
//   KEY[0]   - synchronous active-low reset
//   KEY[1]   - commit the digit on SW[3:0] (active low)
//   KEY[2]   - clear the entry (active low); KEY[3] unused
//   SW[3:0]  - digit to commit; SW[9:4] unused
//   HEX0..3  - active-low 7-segment digits (g..a), HEX0 = most recent digit
//   LEDR     - [3:0] count thermometer, [7] bad digit, [8] OK, [9] LOCK
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_ENTRY | collecting digits; at count 4 waits one cycle, then goes to CHECK
// ST_CHECK | compare buffer against CODE, keys ignored
// ST_OK    | code matched; clear returns to ENTRY
// ST_LOCK  | code wrong; display dashes for LOCK_CYCLES, keys ignored
module code_lock_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LOCK_CYCLES     = 150000000,
  parameter logic [15:0] CODE            = 16'h6256
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [9:0] LEDR
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LKW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LKW-1:0] LK_LAST = LKW'(LOCK_CYCLES - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_OK, ST_LOCK} state_t;

  logic unused_inputs;
  assign unused_inputs = ^{KEY[3], SW[9:4]};

  // index 0 = commit key, index 1 = clear key
  logic [1:0]     sync1_q, sync2_q, level_q, press_q;
  logic [DBW-1:0] db_cnt_q [2];

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      press_q <= '0;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q <= KEY[2:1];
      sync2_q <= sync1_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] != level_q[k]) begin
          if (db_cnt_q[k] == DB_LAST) begin
            level_q[k]  <= sync2_q[k];
            // only the accepted 1->0 edge is an event
            press_q[k]  <= ~sync2_q[k];
            db_cnt_q[k] <= '0;
          end else begin
            db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
          end
        end else begin
          db_cnt_q[k] <= '0;
        end
      end
    end
  end

  logic commit_ev, clear_ev;
  assign commit_ev = press_q[0];
  assign clear_ev  = press_q[1];

  state_t         state_q, state_d;
  logic [2:0]     count_q, count_d;
  logic [15:0]    digits_q, digits_d;
  logic           bad_q, bad_d;
  logic [LKW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    digits_d   = digits_q;
    bad_d      = bad_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_ENTRY: begin
        if (count_q == 3'd4) begin
          state_d = ST_CHECK;
        end else if (clear_ev) begin
          count_d  = 3'd0;
          digits_d = '0;
          bad_d    = 1'b0;
        end else if (commit_ev) begin
          if (SW[3:0] <= 4'd9) begin
            digits_d = {digits_q[11:0], SW[3:0]};
            count_d  = count_q + 3'd1;
            bad_d    = 1'b0;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        lock_cnt_d = '0;
        state_d    = (digits_q == CODE) ? ST_OK : ST_LOCK;
      end
      ST_OK: begin
        if (clear_ev) begin
          state_d  = ST_ENTRY;
          count_d  = 3'd0;
          digits_d = '0;
        end
      end
      ST_LOCK: begin
        if (lock_cnt_q == LK_LAST) begin
          state_d    = ST_ENTRY;
          count_d    = 3'd0;
          digits_d   = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return BLANK;
    endcase
  endfunction

  // Outputs are decoded from next state and registered, so they line up
  // with the state registers without any path from KEY/SW to the pins.
  logic [6:0] hex_d [4];
  logic [3:0] thermo_d;
  logic [9:0] ledr_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hex_d[i] = BLANK;
      if (state_d == ST_LOCK)
        hex_d[i] = DASH;
      else if (state_d == ST_OK || 3'(i) < count_d)
        hex_d[i] = seg7(digits_d[4*i +: 4]);
    end
    case (count_d)
      3'd0:    thermo_d = 4'b0000;
      3'd1:    thermo_d = 4'b0001;
      3'd2:    thermo_d = 4'b0011;
      3'd3:    thermo_d = 4'b0111;
      default: thermo_d = 4'b1111;
    endcase
    if (state_d == ST_OK)   thermo_d = 4'b1111;
    if (state_d == ST_LOCK) thermo_d = 4'b0000;
    ledr_d = {state_d == ST_LOCK, state_d == ST_OK, bad_d, 3'b000, thermo_d};
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      state_q    <= ST_ENTRY;
      count_q    <= 3'd0;
      digits_q   <= '0;
      bad_q      <= 1'b0;
      lock_cnt_q <= '0;
      HEX0       <= BLANK;
      HEX1       <= BLANK;
      HEX2       <= BLANK;
      HEX3       <= BLANK;
      LEDR       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      digits_q   <= digits_d;
      bad_q      <= bad_d;
      lock_cnt_q <= lock_cnt_d;
      HEX0       <= hex_d[0];
      HEX1       <= hex_d[1];
      HEX2       <= hex_d[2];
      HEX3       <= hex_d[3];
      LEDR       <= ledr_d;
    end
  end

endmodule

// File: tb/tb_code_lock_entry.sv
module tb_code_lock_entry;
  localparam int DB = 4;
  localparam int LK = 20;
  localparam logic [15:0] CODE = 16'h6256;
  // two synchronizer flops, DB stable samples, one cycle for the FSM to consume
  localparam int PRESS_LAT = 2 + DB + 1;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [9:0] sw;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [9:0] ledr;

  always #5 clk = ~clk;

  code_lock_entry #(.DEBOUNCE_CYCLES(DB), .LOCK_CYCLES(LK), .CODE(CODE)) dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .LEDR(ledr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: entered digits in order, bad flag, mode 0=entry 1=ok 2=lock
  int          m_dig[$];
  bit          m_bad;
  int          m_mode;
  logic [15:0] code_v = CODE;
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_hex(input int i);
    if (m_mode == 2) return 7'h3F;
    if (i < m_dig.size()) return seg_tab[m_dig[m_dig.size() - 1 - i]];
    return 7'h7F;
  endfunction

  function automatic logic [9:0] exp_ledr();
    if (m_mode == 2) return 10'h200;
    if (m_mode == 1) return 10'h10F;
    return 10'(((1 << m_dig.size()) - 1) | (int'(m_bad) << 7));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".hex0"}, hex0, exp_hex(0));
    chk({tag, ".hex1"}, hex1, exp_hex(1));
    chk({tag, ".hex2"}, hex2, exp_hex(2));
    chk({tag, ".hex3"}, hex3, exp_hex(3));
    chk({tag, ".ledr"}, ledr, exp_ledr());
  endtask

  task automatic model_reset();
    m_dig.delete();
    m_bad  = 0;
    m_mode = 0;
  endtask

  task automatic model_commit(input int d);
    bit match;
    if (m_mode != 0) return;
    if (d > 9) begin
      m_bad = 1;
      return;
    end
    m_dig.push_back(d);
    m_bad = 0;
    if (m_dig.size() == 4) begin
      match = 1;
      for (int i = 0; i < 4; i++)
        if (m_dig[i] != int'(code_v[15 - 4*i -: 4])) match = 0;
      m_mode = match ? 1 : 2;
    end
  endtask

  task automatic model_clear();
    if (m_mode == 2) return;
    m_dig.delete();
    m_bad  = 0;
    m_mode = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    key = 4'b1110;
    repeat (2) @(negedge clk);
    key = 4'b1111;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  task automatic press(input bit commit, input bit clear, input int d, input int hold);
    @(negedge clk);
    sw     = {6'($urandom), 4'(d)};
    key[1] = ~commit;
    key[2] = ~clear;
    repeat (hold) @(negedge clk);
    key[1] = 1'b1;
    key[2] = 1'b1;
    repeat (12) @(negedge clk);
    if (clear) model_clear();
    else if (commit) model_commit(d);
  endtask

  // drive the 4th digit and return the edge count until the thermometer is full
  task automatic fourth_digit(input int d, output int edges);
    edges = 0;
    @(negedge clk);
    sw     = 10'(d);
    key[1] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (ledr[3:0] == 4'hF) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int edges, lock_n, first_lock, dash_err, d, r;
    key = 4'b1111;
    sw  = '0;
    model_reset();

    do_reset();
    check_all("reset");

    // correct code, exact OK timing
    press(1, 0, 6, 10);
    press(1, 0, 2, 10);
    press(1, 0, 5, 10);
    fourth_digit(6, edges);
    chk("press_latency", edges, PRESS_LAT);
    @(posedge clk); #1;
    chk("check_cycle_led8", ledr[8], 1'b0);
    @(posedge clk); #1;
    chk("ok_led8", ledr[8], 1'b1);
    @(negedge clk);
    key[1] = 1'b1;
    repeat (12) @(negedge clk);
    model_commit(6);
    check_all("ok");
    press(1, 0, 1, 10);
    check_all("ok_commit_ignored");
    press(0, 1, 0, 10);
    check_all("ok_clear");

    // wrong code, exact LOCK duration
    press(1, 0, 1, 10);
    press(1, 0, 2, 10);
    press(1, 0, 3, 10);
    fourth_digit(4, edges);
    lock_n = 0; first_lock = 0; dash_err = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (ledr[9]) begin
        lock_n++;
        if (first_lock == 0) first_lock = e;
        if ({hex3, hex2, hex1, hex0} != {4{7'h3F}}) dash_err++;
      end
    end
    chk("lock_start", first_lock, 2);
    chk("lock_cycles", lock_n, LK);
    chk("lock_dash_err", dash_err, 0);
    @(negedge clk);
    key[1] = 1'b1;
    repeat (12) @(negedge clk);
    model_commit(4);
    model_reset();
    check_all("lock_exit");
    press(1, 0, 7, 10);
    check_all("after_lock_commit");

    // invalid digit then valid digit
    press(1, 0, 12, 10);
    check_all("bad_digit");
    press(1, 0, 3, 10);
    check_all("bad_cleared");

    // bounce: 3-cycle pulses must not register, long hold registers once
    press(0, 1, 0, 10);
    @(negedge clk);
    sw = 10'd5;
    for (int b = 0; b < 2; b++) begin
      key[1] = 1'b0;
      repeat (3) @(negedge clk);
      key[1] = 1'b1;
      repeat (3) @(negedge clk);
    end
    key[1] = 1'b0;
    repeat (10) @(negedge clk);
    key[1] = 1'b1;
    repeat (12) @(negedge clk);
    model_commit(5);
    check_all("bounce");

    // commit and clear together act as clear
    press(1, 0, 8, 10);
    check_all("two_digits");
    press(1, 1, 9, 10);
    check_all("commit_and_clear");

    // randomized sequence against the model
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (m_mode == 0 && m_dig.size() < 4 && $urandom_range(0, 1) == 1)
        d = int'(code_v[15 - 4*m_dig.size() -: 4]);
      else
        d = $urandom_range(0, 15);
      if (r <= 6) press(1, 0, d, $urandom_range(5, 12));
      else if (r <= 8) press(0, 1, d, $urandom_range(5, 12));
      else press(1, 1, d, $urandom_range(5, 12));
      check_all($sformatf("rnd%0d", it));
      if (m_mode == 2) begin
        repeat (LK + 5) @(negedge clk);
        model_reset();
        check_all($sformatf("rnd%0d_unlock", it));
      end
    end

    // reset in the middle of LOCK
    do_reset();
    for (int i = 0; i < 4; i++) press(1, 0, 0, 10);
    chk("midlock_led9", ledr[9], 1'b1);
    @(negedge clk);
    key[0] = 1'b0;
    @(posedge clk); #1;
    chk("midlock_reset_ledr", ledr, 10'h000);
    chk("midlock_reset_hex0", hex0, 7'h7F);
    @(negedge clk);
    key[0] = 1'b1;
    model_reset();
    repeat (30) @(negedge clk);
    check_all("post_lock_reset");

    // reset in the middle of a debounce produces no event
    @(negedge clk);
    sw     = 10'd2;
    key[1] = 1'b0;
    repeat (4) @(negedge clk);
    key = 4'b1110;
    repeat (2) @(negedge clk);
    key = 4'b1111;
    repeat (20) @(negedge clk);
    check_all("mid_debounce_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
